// File: rtl/nibble_serial_subtractor_if.sv
// Operand/result handshake bundle for the nibble-serial subtractor.
// The master side supplies operands and consumes results; the slave side is the subtractor.
interface nibble_serial_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, zero
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, zero
    );
endinterface

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle unsigned subtractor: computes a - b - bin one 4-bit slice per clock
// through a ripple-borrow cell, with valid/ready handshakes on both sides.
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    nibble_serial_subtractor_if.slave     bus
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IDXW   = $clog2(NSLICE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;

    logic [3:0]       a_cur;
    logic [3:0]       b_cur;
    logic [3:0]       d_cell;
    logic [4:0]       cc;

    // 4-bit ripple cell: a + ~b + c, where carry-out high means "no borrow".
    assign cc[0] = c_q;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cell
            logic nb;
            logic p;
            assign nb         = ~b_cur[gi];
            assign p          = a_cur[gi] ^ nb;
            assign d_cell[gi] = p ^ cc[gi];
            assign cc[gi+1]   = (a_cur[gi] & nb) | (p & cc[gi]);
        end
    endgenerate

    always_comb begin
        a_cur = '0;
        b_cur = '0;
        for (int k = 0; k < NSLICE; k++) begin
            if (idx_q == IDXW'(k)) begin
                a_cur = a_q[4*k +: 4];
                b_cur = b_q[4*k +: 4];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    c_d     = ~bus.bin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // The extra edge after the last slice derives the flags from the
                // registered difference, keeping zero detect off the ripple path.
                if (idx_q == IDXW'(NSLICE)) begin
                    bout_d  = ~c_q;
                    zero_d  = (diff_q == '0);
                    state_d = DONE;
                end else begin
                    for (int k = 0; k < NSLICE; k++) begin
                        if (idx_q == IDXW'(k)) begin
                            diff_d[4*k +: 4] = d_cell;
                        end
                    end
                    c_d   = cc[4];
                    idx_d = idx_q + IDXW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench for the nibble-serial subtractor at WIDTH = 16, 4 and 32;
// one operation is in flight at a time and a shared driver steers the selected instance.
module tb_nibble_serial_subtractor;
    typedef struct packed {
        logic [31:0] diff;
        logic        bout;
        logic        zero;
    } exp_t;

    logic clk;
    logic rst;
    int   sel;
    int   pass_cnt;
    int   total_cnt;
    exp_t sb[$];

    logic        drv_in_valid;
    logic [31:0] drv_a;
    logic [31:0] drv_b;
    logic        drv_bin;
    logic        drv_out_ready;

    logic        obs_in_ready;
    logic        obs_out_valid;
    logic [31:0] obs_diff;
    logic        obs_bout;
    logic        obs_zero;

    nibble_serial_subtractor_if #(.WIDTH(16)) if16 ();
    nibble_serial_subtractor_if #(.WIDTH(4))  if4  ();
    nibble_serial_subtractor_if #(.WIDTH(32)) if32 ();

    nibble_serial_subtractor #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(if16));
    nibble_serial_subtractor #(.WIDTH(4))  u4  (.clk(clk), .rst(rst), .bus(if4));
    nibble_serial_subtractor #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(if32));

    assign if16.in_valid  = (sel == 16) && drv_in_valid;
    assign if16.a         = drv_a[15:0];
    assign if16.b         = drv_b[15:0];
    assign if16.bin       = drv_bin;
    assign if16.out_ready = (sel == 16) && drv_out_ready;
    assign if4.in_valid   = (sel == 4) && drv_in_valid;
    assign if4.a          = drv_a[3:0];
    assign if4.b          = drv_b[3:0];
    assign if4.bin        = drv_bin;
    assign if4.out_ready  = (sel == 4) && drv_out_ready;
    assign if32.in_valid  = (sel == 32) && drv_in_valid;
    assign if32.a         = drv_a;
    assign if32.b         = drv_b;
    assign if32.bin       = drv_bin;
    assign if32.out_ready = (sel == 32) && drv_out_ready;

    always_comb begin
        obs_in_ready  = if16.in_ready;
        obs_out_valid = if16.out_valid;
        obs_diff      = {16'd0, if16.diff};
        obs_bout      = if16.bout;
        obs_zero      = if16.zero;
        if (sel == 4) begin
            obs_in_ready  = if4.in_ready;
            obs_out_valid = if4.out_valid;
            obs_diff      = {28'd0, if4.diff};
            obs_bout      = if4.bout;
            obs_zero      = if4.zero;
        end else if (sel == 32) begin
            obs_in_ready  = if32.in_ready;
            obs_out_valid = if32.out_valid;
            obs_diff      = if32.diff;
            obs_bout      = if32.bout;
            obs_zero      = if32.zero;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One full transaction: present operands, wait for acceptance, measure latency,
    // optionally stall the output, then pop the expected result at the output handshake.
    task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b,
                         input logic bin, input int hold, input bit probe);
        exp_t        e;
        exp_t        got;
        logic [31:0] mask;
        logic [32:0] full;
        int          guard;
        int          lat;
        sel  = w;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        full = {1'b0, a & mask} - {1'b0, b & mask} - {32'd0, bin};
        e.diff = full[31:0] & mask;
        e.bout = (({1'b0, b & mask} + {32'd0, bin}) > {1'b0, a & mask});
        e.zero = (e.diff == 32'd0);

        drv_a = a; drv_b = b; drv_bin = bin; drv_in_valid = 1'b1;
        drv_out_ready = (hold < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        guard = 0;
        while (obs_in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        total_cnt++;
        if (obs_in_ready !== 1'b1) begin
            $display("FAIL accept_timeout w=%0d: in_ready=%b required 1", w, obs_in_ready);
            drv_in_valid = 1'b0;
            return;
        end else pass_cnt++;
        sb.push_back(e);
        @(negedge clk);
        drv_in_valid = 1'b0;
        drv_a = $urandom; drv_b = $urandom; drv_bin = 1'($urandom_range(0, 1));

        lat = 0;
        while (obs_out_valid !== 1'b1 && lat < 100) begin
            if (hold < 0) drv_out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        total_cnt++;
        if (lat != w / 4 + 1) $display("FAIL latency w=%0d: got %0d edges required %0d", w, lat, w / 4 + 1);
        else pass_cnt++;

        if (hold >= 0) begin
            drv_out_ready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                if (probe && i == 3) begin
                    drv_in_valid = 1'b1; drv_a = 32'hFFFF; drv_b = 32'h1; drv_bin = 1'b0;
                end
                if (probe && i == 5) drv_in_valid = 1'b0;
                @(negedge clk);
                total_cnt++;
                if (obs_out_valid !== 1'b1 || obs_in_ready !== 1'b0 || obs_diff !== e.diff)
                    $display("FAIL stall_hold cyc=%0d: out_valid=%b in_ready=%b diff=%h required 1/0/%h",
                             i, obs_out_valid, obs_in_ready, obs_diff, e.diff);
                else pass_cnt++;
            end
            drv_out_ready = 1'b1;
        end else begin
            drv_out_ready = 1'($urandom_range(0, 1));
        end

        guard = 0;
        while (!(obs_out_valid === 1'b1 && drv_out_ready) && guard < 100) begin
            @(negedge clk);
            if (hold < 0) drv_out_ready = 1'($urandom_range(0, 1));
            guard++;
        end
        if (sb.size() == 0) begin
            total_cnt++;
            $display("FAIL scoreboard_empty w=%0d", w);
        end else begin
            got = sb.pop_front();
            total_cnt++;
            if (obs_diff !== got.diff) $display("FAIL diff w=%0d a=%h b=%h bin=%b: got %h required %h", w, a, b, bin, obs_diff, got.diff);
            else pass_cnt++;
            total_cnt++;
            if (obs_bout !== got.bout) $display("FAIL bout w=%0d a=%h b=%h bin=%b: got %b required %b", w, a, b, bin, obs_bout, got.bout);
            else pass_cnt++;
            total_cnt++;
            if (obs_zero !== got.zero) $display("FAIL zero w=%0d a=%h b=%h bin=%b: got %b required %b", w, a, b, bin, obs_zero, got.zero);
            else pass_cnt++;
        end

        @(negedge clk);
        drv_out_ready = 1'b0;
        total_cnt++;
        if (obs_out_valid !== 1'b0 || obs_in_ready !== 1'b1)
            $display("FAIL post_handshake w=%0d: out_valid=%b in_ready=%b required 0/1", w, obs_out_valid, obs_in_ready);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        sel = 16;
        total_cnt++;
        if (obs_in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", obs_in_ready); else pass_cnt++;
        total_cnt++;
        if (obs_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", obs_out_valid); else pass_cnt++;
        total_cnt++;
        if (obs_diff !== 32'd0) $display("FAIL reset_diff: got %h required 0", obs_diff); else pass_cnt++;
        total_cnt++;
        if (obs_bout !== 1'b0) $display("FAIL reset_bout: got %b required 0", obs_bout); else pass_cnt++;
        total_cnt++;
        if (obs_zero !== 1'b0) $display("FAIL reset_zero: got %b required 0", obs_zero); else pass_cnt++;
    endtask

    task automatic test_basic();
        do_op(16, 32'h1234, 32'h0234, 1'b0, 0, 1'b0);
        do_op(16, 32'h0000, 32'h0001, 1'b0, 0, 1'b0);
    endtask

    task automatic test_equal();
        do_op(16, 32'hBEEF, 32'hBEEF, 1'b0, 0, 1'b0);
        do_op(16, 32'hBEEF, 32'hBEEF, 1'b1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        do_op(16, 32'h00F0, 32'h000F, 1'b0, 10, 1'b1);
        @(negedge clk);
        total_cnt++;
        if (obs_in_ready !== 1'b1 || obs_out_valid !== 1'b0)
            $display("FAIL stall_probe_ignored: in_ready=%b out_valid=%b required 1/0", obs_in_ready, obs_out_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        int guard;
        sel = 16;
        drv_a = 32'h8000; drv_b = 32'h0001; drv_bin = 1'b0; drv_in_valid = 1'b1;
        guard = 0;
        while (obs_in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        drv_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total_cnt++;
        if (obs_out_valid !== 1'b0 || obs_diff !== 32'd0 || obs_in_ready !== 1'b1)
            $display("FAIL abort: out_valid=%b diff=%h in_ready=%b required 0/0000/1", obs_out_valid, obs_diff, obs_in_ready);
        else pass_cnt++;
        do_op(16, 32'h0003, 32'h0005, 1'b0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_op(16, 32'hFFFF, 32'h0001, 1'b1, 0, 1'b0);
        do_op(16, 32'h0001, 32'hFFFF, 1'b0, 0, 1'b0);
    endtask

    task automatic test_sweep(input int w);
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op(w, $urandom, $urandom, 1'($urandom_range(0, 1)), -1, 1'b0);
        end
        do_op(w, 32'h0, 32'h0, 1'b1, -1, 1'b0);
        do_op(w, 32'h5, 32'h5, 1'b0, -1, 1'b0);
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0; sel = 16;
        drv_in_valid = 1'b0; drv_a = '0; drv_b = '0; drv_bin = 1'b0; drv_out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_equal();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_sweep(4);
        test_sweep(32);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
